// File: rtl/riscv_mc_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_mc_pkg
//  Brief    : Shared types for the multi-cycle RV32I sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package riscv_mc_pkg;

    localparam int INSTR_W = 32;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_IMEM_TO  = 2'd1,
        ERR_DMEM_TO  = 2'd2,
        ERR_MISALIGN = 2'd3
    } err_e;

endpackage
`default_nettype wire

// File: rtl/riscv_mc_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_mc_sequencer_if
//  Brief    : Instruction/data memory req/ready handshake bundle.
//  Revision : 1.0 - initial release
// ============================================================================
interface riscv_mc_sequencer_if #(
    parameter int XLEN = 32
);
    import riscv_mc_pkg::*;

    logic               imem_req;
    logic [XLEN-1:0]    imem_addr;
    logic               imem_ready;
    logic [INSTR_W-1:0] imem_rdata;
    logic               dmem_req;
    logic               dmem_we;
    logic               dmem_ready;

    modport master (
        output imem_req, imem_addr, dmem_req, dmem_we,
        input  imem_ready, imem_rdata, dmem_ready
    );

    modport slave (
        input  imem_req, imem_addr, dmem_req, dmem_we,
        output imem_ready, imem_rdata, dmem_ready
    );

endinterface
`default_nettype wire

// File: rtl/riscv_mc_sequencer_wait_timer.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_wait_timer
//  Brief    : Counts request cycles without ready; flags the last allowed one.
//  Revision : 1.0 - initial release
// ============================================================================
module riscv_wait_timer #(
    parameter int WAIT_LIMIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Asserted during the WAIT_LIMIT-th waiting cycle; a ready in that cycle disables it.
    assign expired = enable && (count_q == CNT_W'(WAIT_LIMIT - 1));

endmodule
`default_nettype wire

// File: rtl/riscv_mc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_mc_sequencer
//  Brief    : Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer owning PC, IR, instret.
//  Revision : 1.0 - initial release
// ============================================================================
module riscv_mc_sequencer #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              WAIT_LIMIT = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    riscv_mc_sequencer_if.master              bus,
    input  logic                              is_load,
    input  logic                              is_store,
    input  logic                              is_ebreak,
    input  logic                              reg_wr_dec,
    input  logic                              br_taken,
    input  logic [XLEN-1:0]                   br_target,
    output logic [riscv_mc_pkg::INSTR_W-1:0]  ir,
    output logic [XLEN-1:0]                   pc,
    output logic                              reg_wr,
    output logic                              retire,
    output logic [XLEN-1:0]                   instret,
    output logic                              halt,
    output logic [1:0]                        err_code
);
    import riscv_mc_pkg::*;

    state_e             state_q, state_d;
    err_e               err_q, err_d;
    logic [XLEN-1:0]    pc_q, pc_d;
    logic [XLEN-1:0]    instret_q, instret_d;
    logic [INSTR_W-1:0] ir_q, ir_d;

    logic               w_retire;
    logic               w_reg_wr;
    logic               w_expired;
    logic               w_wait_en;
    logic               w_wait_clr;
    logic [XLEN-1:0]    w_npc;

    assign w_npc      = br_taken ? br_target : (pc_q + XLEN'(4));
    assign w_wait_en  = ((state_q == FETCH) && !bus.imem_ready) ||
                        ((state_q == MEM)   && !bus.dmem_ready);
    assign w_wait_clr = (state_d != state_q);

    riscv_wait_timer #(
        .WAIT_LIMIT (WAIT_LIMIT)
    ) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (w_wait_clr),
        .enable  (w_wait_en),
        .expired (w_expired)
    );

    always_comb begin
        state_d   = state_q;
        err_d     = err_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        instret_d = instret_q;
        w_retire  = 1'b0;
        w_reg_wr  = 1'b0;

        case (state_q)
            FETCH: begin
                if (bus.imem_ready) begin
                    ir_d    = bus.imem_rdata;
                    state_d = DECODE;
                end else if (w_expired) begin
                    state_d = HALT;
                    err_d   = ERR_IMEM_TO;
                end
            end
            DECODE: state_d = is_ebreak ? HALT : EXEC;
            EXEC:   state_d = (is_load || is_store) ? MEM : WB;
            MEM: begin
                if (bus.dmem_ready) begin
                    if (is_store) begin
                        w_retire = 1'b1;
                    end else begin
                        state_d = WB;
                    end
                end else if (w_expired) begin
                    state_d = HALT;
                    err_d   = ERR_DMEM_TO;
                end
            end
            WB: begin
                w_retire = 1'b1;
                w_reg_wr = reg_wr_dec;
            end
            HALT:    state_d = HALT;
            default: state_d = HALT;
        endcase

        // A misaligned next PC still retires the current instruction, then stops.
        if (w_retire) begin
            instret_d = instret_q + XLEN'(1);
            if (w_npc[1:0] != 2'b00) begin
                state_d = HALT;
                err_d   = ERR_MISALIGN;
            end else begin
                pc_d    = w_npc;
                state_d = FETCH;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= FETCH;
            err_q     <= ERR_NONE;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            err_q     <= err_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            instret_q <= instret_d;
        end
    end

    assign bus.imem_req  = (state_q == FETCH);
    assign bus.imem_addr = pc_q;
    assign bus.dmem_req  = (state_q == MEM);
    assign bus.dmem_we   = (state_q == MEM) && is_store;

    assign ir       = ir_q;
    assign pc       = pc_q;
    assign instret  = instret_q;
    assign reg_wr   = w_reg_wr;
    assign retire   = w_retire;
    assign halt     = (state_q == HALT);
    assign err_code = err_q;

endmodule
`default_nettype wire

// File: tb/tb_riscv_mc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_riscv_mc_sequencer
//  Brief    : Directed self-checking bench for the multi-cycle sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_mc_sequencer;

    localparam logic [31:0] ADDI   = 32'h0010_0093;
    localparam logic [31:0] LW     = 32'h0000_A103;
    localparam logic [31:0] SW     = 32'h0020_A023;
    localparam logic [31:0] BEQ    = 32'h0200_0263;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    logic        clk = 1'b0;
    logic        reset;
    logic        is_load, is_store, is_ebreak, reg_wr_dec, br_taken;
    logic [31:0] br_target;
    logic [31:0] ir, pc, instret;
    logic        reg_wr, retire, halt;
    logic [1:0]  err_code;

    int n_pass  = 0;
    int n_total = 0;

    riscv_mc_sequencer_if #(.XLEN(32)) bus ();

    riscv_mc_sequencer #(
        .XLEN       (32),
        .RESET_PC   (32'h0),
        .WAIT_LIMIT (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .is_load    (is_load),
        .is_store   (is_store),
        .is_ebreak  (is_ebreak),
        .reg_wr_dec (reg_wr_dec),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .ir         (ir),
        .pc         (pc),
        .reg_wr     (reg_wr),
        .retire     (retire),
        .instret    (instret),
        .halt       (halt),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    task automatic set_dec(input logic l, input logic s, input logic e, input logic w);
        is_load = l; is_store = s; is_ebreak = e; reg_wr_dec = w;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        bus.imem_ready = 1'b0; bus.imem_rdata = '0; bus.dmem_ready = 1'b0;
        set_dec(0, 0, 0, 0); br_taken = 1'b0; br_target = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Executes one zero-wait ADDI from the current FETCH window; ends in the next FETCH window.
    task automatic run_addi();
        bus.imem_ready = 1'b1; bus.imem_rdata = ADDI; bus.dmem_ready = 1'b0;
        set_dec(0, 0, 0, 1); br_taken = 1'b0;
        for (int k = 2; k <= 5; k++) begin
            @(negedge clk);
            bus.imem_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.imem_ready = 1'b0; bus.imem_rdata = '0; bus.dmem_ready = 1'b0;
        set_dec(0, 0, 0, 0); br_taken = 1'b0; br_target = '0;
        @(negedge clk); #1;
        n_total++; if (pc !== 32'h0)       $display("FAIL rst_pc: got %h want %h", pc, 32'h0); else n_pass++;
        n_total++; if (ir !== 32'h0)       $display("FAIL rst_ir: got %h want %h", ir, 32'h0); else n_pass++;
        n_total++; if (instret !== 32'h0)  $display("FAIL rst_instret: got %h want 0", instret); else n_pass++;
        n_total++; if (halt !== 1'b0)      $display("FAIL rst_halt: got %b want 0", halt); else n_pass++;
        n_total++; if (err_code !== 2'd0)  $display("FAIL rst_err: got %0d want 0", err_code); else n_pass++;
        n_total++; if (bus.imem_req !== 1'b1) $display("FAIL rst_imem_req: got %b want 1", bus.imem_req); else n_pass++;
        n_total++; if (bus.dmem_req !== 1'b0) $display("FAIL rst_dmem_req: got %b want 0", bus.dmem_req); else n_pass++;
        n_total++; if ({reg_wr, retire} !== 2'b00) $display("FAIL rst_strobes: got %b want 00", {reg_wr, retire}); else n_pass++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_alu();
        bus.imem_ready = 1'b1; bus.imem_rdata = ADDI; set_dec(0, 0, 0, 1); br_taken = 1'b0;
        #1;
        n_total++; if (bus.imem_addr !== 32'h0) $display("FAIL alu_addr: got %h want 0", bus.imem_addr); else n_pass++;
        for (int k = 2; k <= 4; k++) begin
            @(negedge clk); bus.imem_ready = 1'b0; #1;
            if (k == 2) begin
                n_total++; if (ir !== ADDI) $display("FAIL alu_ir: got %h want %h", ir, ADDI); else n_pass++;
            end
            if (k < 4) begin
                n_total++; if (reg_wr !== 1'b0) $display("FAIL alu_early_wr c%0d: got %b want 0", k, reg_wr); else n_pass++;
            end else begin
                n_total++; if ({reg_wr, retire} !== 2'b11) $display("FAIL alu_wb: got %b want 11", {reg_wr, retire}); else n_pass++;
            end
        end
        @(negedge clk); #1;
        n_total++; if (pc !== 32'h4)      $display("FAIL alu_pc: got %h want 4", pc); else n_pass++;
        n_total++; if (instret !== 32'h1) $display("FAIL alu_instret: got %0d want 1", instret); else n_pass++;
        n_total++; if (reg_wr !== 1'b0)   $display("FAIL alu_wr_drop: got %b want 0", reg_wr); else n_pass++;
    endtask

    task automatic test_load();
        int n_dreq = 0, n_wr = 0, ret_cyc = 0;
        logic ok = 1'b1;
        bus.imem_ready = 1'b1; bus.imem_rdata = LW; set_dec(1, 0, 0, 1); bus.dmem_ready = 1'b0;
        #1;
        n_total++; if (bus.imem_addr !== 32'h4) $display("FAIL ld_addr: got %h want 4", bus.imem_addr); else n_pass++;
        for (int k = 2; k <= 8; k++) begin
            @(negedge clk); bus.imem_ready = 1'b0; bus.dmem_ready = (k == 7); #1;
            n_dreq += int'(bus.dmem_req);
            n_wr   += int'(reg_wr);
            if (retire === 1'b1) ret_cyc = k;
            if (bus.dmem_req === 1'b1 && (bus.dmem_we !== 1'b0 || bus.imem_addr !== 32'h4)) ok = 1'b0;
        end
        n_total++; if (n_dreq != 4)  $display("FAIL ld_dmem_req_cycles: got %0d want 4", n_dreq); else n_pass++;
        n_total++; if (ok !== 1'b1)  $display("FAIL ld_stable: got %b want 1", ok); else n_pass++;
        n_total++; if (n_wr != 1)    $display("FAIL ld_reg_wr_count: got %0d want 1", n_wr); else n_pass++;
        n_total++; if (ret_cyc != 8) $display("FAIL ld_retire_cycle: got %0d want 8", ret_cyc); else n_pass++;
        @(negedge clk); bus.dmem_ready = 1'b0; #1;
        n_total++; if (pc !== 32'h8)      $display("FAIL ld_pc: got %h want 8", pc); else n_pass++;
        n_total++; if (instret !== 32'h2) $display("FAIL ld_instret: got %0d want 2", instret); else n_pass++;
    endtask

    task automatic test_store();
        int n_ret = 0, n_wr = 0;
        bus.imem_ready = 1'b1; bus.imem_rdata = SW; set_dec(0, 1, 0, 0); bus.dmem_ready = 1'b1;
        for (int k = 2; k <= 4; k++) begin
            @(negedge clk); bus.imem_ready = 1'b0; #1;
            n_ret += int'(retire);
            n_wr  += int'(reg_wr);
            if (k == 4) begin
                n_total++; if ({bus.dmem_req, bus.dmem_we} !== 2'b11) $display("FAIL st_req_we: got %b want 11", {bus.dmem_req, bus.dmem_we}); else n_pass++;
                n_total++; if (retire !== 1'b1) $display("FAIL st_retire_ack: got %b want 1", retire); else n_pass++;
            end
        end
        n_total++; if (n_ret != 1) $display("FAIL st_retire_count: got %0d want 1", n_ret); else n_pass++;
        n_total++; if (n_wr != 0)  $display("FAIL st_reg_wr: got %0d want 0", n_wr); else n_pass++;
        @(negedge clk); bus.dmem_ready = 1'b0; #1;
        n_total++; if (pc !== 32'hC)      $display("FAIL st_pc: got %h want c", pc); else n_pass++;
        n_total++; if (instret !== 32'h3) $display("FAIL st_instret: got %0d want 3", instret); else n_pass++;
        n_total++; if (bus.dmem_req !== 1'b0) $display("FAIL st_dmem_drop: got %b want 0", bus.dmem_req); else n_pass++;
    endtask

    task automatic test_branch();
        bus.imem_ready = 1'b1; bus.imem_rdata = BEQ; set_dec(0, 0, 0, 0);
        br_taken = 1'b1; br_target = 32'h40;
        for (int k = 2; k <= 4; k++) begin
            @(negedge clk); bus.imem_ready = 1'b0; #1;
        end
        n_total++; if ({retire, reg_wr} !== 2'b10) $display("FAIL br_wb: got %b want 10", {retire, reg_wr}); else n_pass++;
        @(negedge clk); #1;
        n_total++; if (bus.imem_addr !== 32'h40) $display("FAIL br_target_addr: got %h want 40", bus.imem_addr); else n_pass++;
        n_total++; if (instret !== 32'h4) $display("FAIL br_instret: got %0d want 4", instret); else n_pass++;
        bus.imem_ready = 1'b1; br_target = 32'h42;
        for (int k = 2; k <= 4; k++) begin
            @(negedge clk); bus.imem_ready = 1'b0; #1;
        end
        n_total++; if (retire !== 1'b1) $display("FAIL mis_retire: got %b want 1", retire); else n_pass++;
        @(negedge clk); #1;
        n_total++; if (halt !== 1'b1)     $display("FAIL mis_halt: got %b want 1", halt); else n_pass++;
        n_total++; if (err_code !== 2'd3) $display("FAIL mis_err: got %0d want 3", err_code); else n_pass++;
        n_total++; if (pc !== 32'h40)     $display("FAIL mis_pc_hold: got %h want 40", pc); else n_pass++;
        n_total++; if (instret !== 32'h5) $display("FAIL mis_instret: got %0d want 5", instret); else n_pass++;
        n_total++; if (bus.imem_req !== 1'b0) $display("FAIL mis_imem_req: got %b want 0", bus.imem_req); else n_pass++;
        br_taken = 1'b0;
    endtask

    task automatic test_timeout();
        int n_req = 0;
        apply_reset();
        for (int k = 1; k <= 17; k++) begin
            if (k > 1) @(negedge clk);
            #1;
            if (k <= 16) n_req += int'(bus.imem_req);
            if (k == 16) begin
                n_total++; if (halt !== 1'b0) $display("FAIL ito_early_halt: got %b want 0", halt); else n_pass++;
            end
        end
        n_total++; if (n_req != 16) $display("FAIL ito_req_cycles: got %0d want 16", n_req); else n_pass++;
        n_total++; if ({halt, err_code} !== 3'b101) $display("FAIL ito_halt_err: got %b want 101", {halt, err_code}); else n_pass++;
        n_total++; if (bus.imem_req !== 1'b0) $display("FAIL ito_req_drop: got %b want 0", bus.imem_req); else n_pass++;

        // ready arriving on the 16th waiting cycle must still complete the fetch
        apply_reset();
        bus.imem_rdata = ADDI; set_dec(0, 0, 0, 1);
        for (int k = 1; k <= 16; k++) begin
            if (k > 1) @(negedge clk);
            bus.imem_ready = (k == 16);
            #1;
        end
        for (int k = 17; k <= 20; k++) begin
            @(negedge clk); bus.imem_ready = 1'b0; #1;
            if (k == 17) begin
                n_total++; if ({halt, ir} !== {1'b0, ADDI}) $display("FAIL ilate_fetch: got %b/%h want 0/%h", halt, ir, ADDI); else n_pass++;
            end
        end
        n_total++; if ({pc, instret} !== {32'h4, 32'h1}) $display("FAIL ilate_commit: got %h/%0d want 4/1", pc, instret); else n_pass++;

        apply_reset();
        n_req = 0;
        bus.imem_ready = 1'b1; bus.imem_rdata = LW; set_dec(1, 0, 0, 1);
        for (int k = 2; k <= 20; k++) begin
            @(negedge clk); bus.imem_ready = 1'b0; #1;
            if (k <= 19) n_req += int'(bus.dmem_req);
        end
        n_total++; if (n_req != 16) $display("FAIL dto_req_cycles: got %0d want 16", n_req); else n_pass++;
        n_total++; if ({halt, err_code} !== 3'b110) $display("FAIL dto_halt_err: got %b want 110", {halt, err_code}); else n_pass++;
        n_total++; if ({bus.dmem_req, instret} !== {1'b0, 32'h0}) $display("FAIL dto_state: got %b/%0d want 0/0", bus.dmem_req, instret); else n_pass++;
    endtask

    task automatic test_ebreak();
        apply_reset();
        run_addi();
        bus.imem_ready = 1'b1; bus.imem_rdata = EBREAK; set_dec(0, 0, 1, 0);
        @(negedge clk); #1;
        n_total++; if (retire !== 1'b0) $display("FAIL eb_decode_retire: got %b want 0", retire); else n_pass++;
        for (int k = 3; k <= 6; k++) begin
            @(negedge clk); #1;
            if (k == 3) begin
                n_total++; if ({halt, err_code} !== 3'b100) $display("FAIL eb_halt: got %b want 100", {halt, err_code}); else n_pass++;
            end
        end
        n_total++; if (instret !== 32'h1) $display("FAIL eb_instret: got %0d want 1", instret); else n_pass++;
        n_total++; if ({pc, ir} !== {32'h4, EBREAK}) $display("FAIL eb_hold: got %h/%h want 4/%h", pc, ir, EBREAK); else n_pass++;
        n_total++; if ({bus.imem_req, bus.dmem_req, halt} !== 3'b001) $display("FAIL eb_quiet: got %b want 001", {bus.imem_req, bus.dmem_req, halt}); else n_pass++;
    endtask

    task automatic test_reset_mid_mem();
        apply_reset();
        run_addi();
        bus.imem_ready = 1'b1; bus.imem_rdata = LW; set_dec(1, 0, 0, 1); bus.dmem_ready = 1'b0;
        for (int k = 2; k <= 5; k++) begin
            @(negedge clk); bus.imem_ready = 1'b0; #1;
        end
        n_total++; if ({bus.dmem_req, pc} !== {1'b1, 32'h4}) $display("FAIL rm_in_mem: got %b/%h want 1/4", bus.dmem_req, pc); else n_pass++;
        #1; reset = 1'b1; #1;
        n_total++; if (bus.dmem_req !== 1'b0) $display("FAIL rm_dmem_drop: got %b want 0", bus.dmem_req); else n_pass++;
        n_total++; if (pc !== 32'h0)          $display("FAIL rm_pc: got %h want 0", pc); else n_pass++;
        n_total++; if ({retire, reg_wr, instret} !== {2'b00, 32'h0}) $display("FAIL rm_no_retire: got %b%b/%0d want 00/0", retire, reg_wr, instret); else n_pass++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_branch();
        test_timeout();
        test_ebreak();
        test_reset_mid_mem();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time %0t exceeded limit 200000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
